main_ctrl_fsm: RTL
==================

Name: main_ctrl_fsm

Overview:
- Control unit directly upstream of the single-cycle datapath: decodes the fetched 32-bit instruction and drives ALUsrc, we, re, MemtoReg, imm_src, rg_wrt_en and Operation.
- Adds a small FSM so load/store can wait on a data-memory ready handshake, stalling the PC via pc_en.
- Counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
- MEM_TIMEOUT, 15, max MEM_WAIT cycles without mem_ready before trapping (1..255)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instruction  in  32  current instruction from instruction memory
- mem_ready  in  1  data memory completed the pending access this cycle
- ALUsrc  out  1  0 = immediate to ALU SrcB, 1 = rs2 data
- imm_src  out  2  00 I-type, 01 S-type, 10 B-type, 11 U-type
- Operation  out  4  ALU op code (package encoding)
- rg_wrt_en  out  1  register file write enable
- MemtoReg  out  1  0 = ALUResult to write-back, 1 = read_data
- re  out  1  data memory read enable
- we  out  1  data memory write enable
- pc_en  out  1  PC register loads PC+4 at this edge only when 1
- trap  out  1  sticky error flag
- trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
- States: EXEC, MEM_WAIT, TRAP. Reset -> EXEC. instret = 0, trap = 0, trap_cause = 00, wait counter = 0.
- While reset is high, rg_wrt_en, we, re and pc_en are forced to 0 regardless of instruction. Other outputs are 0.
- Decode (opcode = instruction[6:0]):
  - R-type 0110011: ALUsrc = 1. Operation from funct3 plus funct7[5]: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT.
  - I-ALU 0010011: ALUsrc = 0, imm_src = 00. Same ops, except SUB is not legal; funct7[5] is used only for SRAI.
  - LOAD 0000011 with funct3 = 010 (LW): ALUsrc = 0, imm_src = 00, Operation = ADD, MemtoReg = 1.
  - STORE 0100011 with funct3 = 010 (SW): ALUsrc = 0, imm_src = 01, Operation = ADD.
  - Anything else is illegal: any other opcode, funct3 or funct7 combination, or instruction[1:0] != 11.
- EXEC:
  - ALU op: rg_wrt_en = 1, pc_en = 1. Retires in 1 cycle; instret += 1; stay in EXEC.
  - LW/SW: datapath controls driven, re/we/rg_wrt_en/pc_en = 0. Go to MEM_WAIT and clear the wait counter.
  - Illegal: all enables 0. Go to TRAP with trap_cause = 01.
- MEM_WAIT:
  - Decode controls are held from the instruction, which is stable because the PC is stalled.
  - Drive re = 1 (LW) or we = 1 (SW) every cycle. The wait counter increments each cycle.
  - mem_ready = 1: LW also asserts rg_wrt_en = 1 and MemtoReg = 1. pc_en = 1, instret += 1, return to EXEC. Minimum memory op latency is 2 cycles.
  - Counter reaches MEM_TIMEOUT with mem_ready = 0: go to TRAP, trap_cause = 10, no write-back, no PC advance.
  - mem_ready and the timeout in the same cycle: mem_ready wins and the instruction retires.
  - Holding we over several cycles rewrites identical data and is allowed.
- TRAP: all enables 0, pc_en = 0. trap = 1 is sticky. Only reset exits.
- instret wraps modulo 2^CNT_W.
- Reset asserted mid-MEM_WAIT: state returns to EXEC immediately. No write-back occurs and no instret increment.
- Outputs are combinational from state plus instruction. trap, trap_cause and instret are registered.

Decomposition:
- Package ctrl_pkg: state enum; opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE); ALU op constants; imm_src constants; trap cause constants.
- ALU op constants: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000.
- Imm_src constants: IMM_I 00, IMM_S 01, IMM_B 10, IMM_U 11.
- One sub-module, alu_decoder: purely combinational funct3/funct7/opcode -> Operation plus an illegal flag. The FSM and counters stay in main_ctrl_fsm.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) after reset -> same cycle ALUsrc = 1, Operation = 0010, rg_wrt_en = 1, pc_en = 1; instret 0 -> 1 at the edge.
- ADDI x5,x0,7 (0x00700293) -> ALUsrc = 0, imm_src = 00, Operation = 0010, rg_wrt_en = 1, pc_en = 1, single cycle.
- LW x6,4(x0) (0x00402303) with mem_ready high on the 3rd MEM_WAIT cycle:
  - EXEC cycle: re = 0, pc_en = 0.
  - Then re = 1 for 3 cycles; rg_wrt_en = 1, MemtoReg = 1 and pc_en = 1 only on the ready cycle.
  - Total 4 cycles; instret += 1.
- SW x6,8(x0) (0x00602423), mem_ready never asserted, MEM_TIMEOUT = 15 -> we = 1 for 15 cycles, then trap = 1, trap_cause = 10, pc_en stays 0 until reset.
- Opcode 0x0000007F, then valid ADD -> trap = 1, trap_cause = 01; the following ADD gives no rg_wrt_en; instret unchanged.
- Assert reset in the 2nd MEM_WAIT cycle of an LW -> re and rg_wrt_en drop asynchronously; after release state = EXEC, instret = 0, trap = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the main control unit.
// Holds the FSM state enum, opcode/ALU/immediate encodings and trap causes.
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_EXEC     = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_TRAP     = 2'b10
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_U = 2'b11;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_MEM_TO  = 2'b10;

  function automatic logic is_mem_op(
    input logic [6:0] opc
  );
    return (opc == OP_LOAD) || (opc == OP_STORE);
  endfunction

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Bundle between the control unit and the datapath / data memory.
// master: control unit (reads instruction, mem_ready; drives controls,
// trap status and retired count). slave: datapath side.
interface main_ctrl_fsm_if #(
  parameter int CNT_W = 32
);

  logic [31:0]      instruction;
  logic             mem_ready;
  logic             ALUsrc;
  logic [1:0]       imm_src;
  logic [3:0]       Operation;
  logic             rg_wrt_en;
  logic             MemtoReg;
  logic             re;
  logic             we;
  logic             pc_en;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instruction,
    input  mem_ready,
    output ALUsrc,
    output imm_src,
    output Operation,
    output rg_wrt_en,
    output MemtoReg,
    output re,
    output we,
    output pc_en,
    output trap,
    output trap_cause,
    output instret
  );

  modport slave (
    output instruction,
    output mem_ready,
    input  ALUsrc,
    input  imm_src,
    input  Operation,
    input  rg_wrt_en,
    input  MemtoReg,
    input  re,
    input  we,
    input  pc_en,
    input  trap,
    input  trap_cause,
    input  instret
  );

endinterface

// File: rtl/alu_decoder.sv
// Combinational opcode/funct3/funct7 -> ALU operation plus illegal flag.
// Ports: opcode_i, funct3_i, funct7_i in; op_o, illegal_o out.
module alu_decoder (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] op_o,
  output logic       illegal_o
);
  import ctrl_pkg::*;

  logic f7_zero;
  logic f7_alt;

  always_comb begin
    f7_zero   = (funct7_i == 7'b0000000);
    f7_alt    = (funct7_i == 7'b0100000);
    op_o      = ALU_ADD;
    illegal_o = 1'b0;
    unique case (1'b1)
      (opcode_i == OP_R): begin
        case (funct3_i)
          3'b000: begin
            op_o      = f7_alt ? ALU_SUB : ALU_ADD;
            illegal_o = !(f7_zero || f7_alt);
          end
          3'b001: begin
            op_o      = ALU_SLL;
            illegal_o = !f7_zero;
          end
          3'b010: begin
            op_o      = ALU_SLT;
            illegal_o = !f7_zero;
          end
          3'b100: begin
            op_o      = ALU_XOR;
            illegal_o = !f7_zero;
          end
          3'b101: begin
            op_o      = f7_alt ? ALU_SRA : ALU_SRL;
            illegal_o = !(f7_zero || f7_alt);
          end
          3'b110: begin
            op_o      = ALU_OR;
            illegal_o = !f7_zero;
          end
          3'b111: begin
            op_o      = ALU_AND;
            illegal_o = !f7_zero;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      (opcode_i == OP_I): begin
        // funct7 only matters for the shift-immediate forms
        case (funct3_i)
          3'b000: op_o = ALU_ADD;
          3'b001: begin
            op_o      = ALU_SLL;
            illegal_o = !f7_zero;
          end
          3'b010: op_o = ALU_SLT;
          3'b100: op_o = ALU_XOR;
          3'b101: begin
            op_o      = f7_alt ? ALU_SRA : ALU_SRL;
            illegal_o = !(f7_zero || f7_alt);
          end
          3'b110: op_o = ALU_OR;
          3'b111: op_o = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      (opcode_i == OP_LOAD): begin
        op_o      = ALU_ADD;
        illegal_o = (funct3_i != F3_WORD);
      end
      (opcode_i == OP_STORE): begin
        op_o      = ALU_ADD;
        illegal_o = (funct3_i != F3_WORD);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Main control unit: decodes the instruction, waits on data memory for
// LW/SW, stalls the PC, counts retired instructions and traps.
// Ports: clk, reset (async, active-high); bus (master) carries
// instruction/mem_ready in and all controls, trap status, instret out.
module main_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  main_ctrl_fsm_if.master bus
);
  import ctrl_pkg::*;

  // wait counter value seen in the last allowed MEM_WAIT cycle
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;

  logic [6:0] opcode;
  logic [3:0] dec_op;
  logic       dec_ill;
  logic       is_r;
  logic       is_ld;
  logic       is_st;
  logic       is_mem;
  logic       unused_bits;

  logic       alusrc;
  logic [1:0] imm;
  logic [3:0] op;
  logic       rg_we;
  logic       m2r;
  logic       rd_en;
  logic       wr_en;
  logic       pc_adv;

  assign opcode = bus.instruction[6:0];
  assign is_r   = (opcode == OP_R);
  assign is_ld  = (opcode == OP_LOAD);
  assign is_st  = (opcode == OP_STORE);
  assign is_mem = is_mem_op(opcode);

  // register indices and immediates belong to the datapath
  assign unused_bits = ^{bus.instruction[24:15],
                         bus.instruction[11:7]};

  alu_decoder u_dec (
    .opcode_i  (opcode),
    .funct3_i  (bus.instruction[14:12]),
    .funct7_i  (bus.instruction[31:25]),
    .op_o      (dec_op),
    .illegal_o (dec_ill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_EXEC;
      wcnt_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= TC_NONE;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    alusrc    = 1'b0;
    imm       = IMM_I;
    op        = ALU_AND;
    rg_we     = 1'b0;
    m2r       = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    pc_adv    = 1'b0;
    unique case (state_q)
      S_EXEC: begin
        if (dec_ill) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_ILLEGAL;
        end else begin
          alusrc = is_r;
          imm    = is_st ? IMM_S : IMM_I;
          op     = dec_op;
          if (is_mem) begin
            state_d = S_MEM_WAIT;
            wcnt_d  = '0;
          end else begin
            rg_we     = 1'b1;
            pc_adv    = 1'b1;
            instret_d = instret_q + CNT_W'(1);
          end
        end
      end
      S_MEM_WAIT: begin
        // PC is stalled, so the instruction is still the LW/SW
        imm    = is_st ? IMM_S : IMM_I;
        op     = dec_op;
        rd_en  = is_ld;
        wr_en  = is_st;
        wcnt_d = wcnt_q + 8'd1;
        // a ready in the timeout cycle still retires
        if (bus.mem_ready) begin
          rg_we     = is_ld;
          m2r       = is_ld;
          pc_adv    = 1'b1;
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_EXEC;
        end else if (wcnt_q == TO_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_MEM_TO;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_EXEC;
    endcase
    // outputs follow reset immediately, not at the next edge
    if (reset) begin
      alusrc = 1'b0;
      imm    = IMM_I;
      op     = ALU_AND;
      rg_we  = 1'b0;
      m2r    = 1'b0;
      rd_en  = 1'b0;
      wr_en  = 1'b0;
      pc_adv = 1'b0;
    end
  end

  assign bus.ALUsrc     = alusrc;
  assign bus.imm_src    = imm;
  assign bus.Operation  = op;
  assign bus.rg_wrt_en  = rg_we;
  assign bus.MemtoReg   = m2r;
  assign bus.re         = rd_en;
  assign bus.we         = wr_en;
  assign bus.pc_en      = pc_adv;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

endmodule
